gd_controller: RTL and testbench

//  Sequencing FSM for the gradient-descent linear-regression datapath (theta_0/theta_1 update engine).

---
 rtl/gd_pkg.sv | 28 ++
 rtl/gd_controller.sv | 155 +++++++++++++++
 tb/tb_gd_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/gd_pkg.sv
// Shared types and default timing for the gradient-descent sequencing controller.
package gd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_WAIT_D = 3'd2,
    ST_CHECK  = 3'd3,
    ST_WAIT_U = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Datapath theta-register input mux selects
  localparam logic [1:0] SEL_INIT = 2'b00;
  localparam logic [1:0] SEL_ITER = 2'b01;

  // Pipeline depth of the datapath multiplier
  localparam int unsigned MULT_PIPE_DEPTH = 2;

  // Derivative: error subtract stage plus the multiplier
  localparam int unsigned GD_LAT_DERIV  = MULT_PIPE_DEPTH + 1;
  // Update: derivative plus learning-rate scale and theta subtract stages
  localparam int unsigned GD_LAT_UPDATE = GD_LAT_DERIV + 2;

  localparam int unsigned GD_MAX_ITER = 255;
  localparam int unsigned GD_ITER_W   = 8;

endpackage

// File: rtl/gd_controller.sv
// Sequencing FSM for the theta_0/theta_1 gradient-descent update datapath.
// The latency counter is zero in each theta-load cycle (T) and counts the
// cycles since; CHECK happens at T+LAT_DERIV, the next load at T+LAT_UPDATE.
module gd_controller
  import gd_pkg::*;
#(
  parameter int unsigned LAT_DERIV  = GD_LAT_DERIV,
  parameter int unsigned LAT_UPDATE = GD_LAT_UPDATE,
  parameter int unsigned MAX_ITER   = GD_MAX_ITER,
  parameter int unsigned ITER_W     = GD_ITER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              conv_flag_in,
  output logic              en_theta_0,
  output logic              en_theta_1,
  output logic [1:0]        sel_theta_0,
  output logic [1:0]        sel_theta_1,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam int unsigned CNT_W = $clog2(LAT_UPDATE);

  localparam logic [CNT_W-1:0]  CNT_CHECK = CNT_W'(LAT_DERIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LAT_UPDATE - 1);
  localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              en_q, en_d;
  logic [1:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              conv_q, conv_d;
  logic              tmo_q, tmo_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              load;

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    en_d    = 1'b0;
    sel_d   = sel_q;
    conv_d  = conv_q;
    tmo_d   = tmo_q;
    iter_d  = iter_q;
    load    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          state_d = ST_INIT;
          en_d    = 1'b1;
          sel_d   = SEL_INIT;
          conv_d  = 1'b0;
          tmo_d   = 1'b0;
          iter_d  = '0;
        end
      end
      ST_INIT, ST_WAIT_D: begin
        state_d = (cnt_q == CNT_CHECK) ? ST_CHECK : ST_WAIT_D;
      end
      ST_CHECK: begin
        if (conv_flag_in) begin
          state_d = ST_DONE;
          conv_d  = 1'b1;
        end else if (iter_q == ITER_MAX) begin
          state_d = ST_DONE;
          tmo_d   = 1'b1;
        end else if (cnt_q == CNT_LOAD) begin
          load = 1'b1;
        end else begin
          state_d = ST_WAIT_U;
        end
      end
      ST_WAIT_U: begin
        if (cnt_q == CNT_LOAD) load = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Iterated theta load opens a new derivative window
    if (load) begin
      state_d = (LAT_DERIV == 1) ? ST_CHECK : ST_WAIT_D;
      cnt_d   = '0;
      en_d    = 1'b1;
      sel_d   = SEL_ITER;
      iter_d  = iter_q + ITER_W'(1);
    end

    // Abort leaves status untouched and drops straight back to IDLE
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      en_d    = 1'b0;
      sel_d   = sel_q;
      conv_d  = conv_q;
      tmo_d   = tmo_q;
      iter_d  = iter_q;
    end

    busy_d = (state_d == ST_INIT) || (state_d == ST_WAIT_D) ||
             (state_d == ST_CHECK) || (state_d == ST_WAIT_U);
    done_d = (state_d == ST_DONE);
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      sel_q   <= SEL_INIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      tmo_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      conv_q  <= conv_d;
      tmo_q   <= tmo_d;
      iter_q  <= iter_d;
    end
  end

  assign en_theta_0  = en_q;
  assign en_theta_1  = en_q;
  assign sel_theta_0 = sel_q;
  assign sel_theta_1 = sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign converged   = conv_q;
  assign timeout     = tmo_q;
  assign iter_count  = iter_q;

endmodule

// File: tb/tb_gd_controller.sv
// Directed self-checking bench for gd_controller (default and MAX_ITER=4 instances).
module tb_gd_controller;

  logic       clk = 1'b0;
  logic       rst, start, start2, abort, conv;

  logic       en0, en1, busy, done, cvg, tmo;
  logic [1:0] sel0, sel1;
  logic [7:0] iter;

  logic       en0_b, en1_b, busy_b, done_b, cvg_b, tmo_b;
  logic [1:0] sel0_b, sel1_b;
  logic [7:0] iter_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gd_controller dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .conv_flag_in(conv),
    .en_theta_0(en0), .en_theta_1(en1), .sel_theta_0(sel0), .sel_theta_1(sel1),
    .busy(busy), .done(done), .converged(cvg), .timeout(tmo), .iter_count(iter)
  );

  gd_controller #(.MAX_ITER(4)) dut_b (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .conv_flag_in(conv),
    .en_theta_0(en0_b), .en_theta_1(en1_b), .sel_theta_0(sel0_b), .sel_theta_1(sel1_b),
    .busy(busy_b), .done(done_b), .converged(cvg_b), .timeout(tmo_b), .iter_count(iter_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int loads;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0; conv = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_en", {31'd0, en0}, 0);
    chk("rst_sel", {30'd0, sel0}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_cvg", {31'd0, cvg}, 0);
    chk("rst_tmo", {31'd0, tmo}, 0);
    chk("rst_iter", {24'd0, iter}, 0);

    // 1: converge at first check
    conv = 1'b1; start = 1'b1;
    tick(); start = 1'b0;                          // S+1
    chk("s1_en_init", {31'd0, en0}, 1);
    chk("s1_en1_init", {31'd0, en1}, 1);
    chk("s1_sel_init", {30'd0, sel0}, 0);
    chk("s1_busy", {31'd0, busy}, 1);
    tick();                                        // S+2
    chk("s1_en_off", {31'd0, en0}, 0);
    tick(); tick();                                // S+4
    chk("s1_no_done_check", {31'd0, done}, 0);
    tick();                                        // S+5
    chk("s1_done", {31'd0, done}, 1);
    chk("s1_busy_done", {31'd0, busy}, 0);
    chk("s1_cvg", {31'd0, cvg}, 1);
    chk("s1_iter", {24'd0, iter}, 0);
    tick();                                        // S+6
    chk("s1_done_pulse", {31'd0, done}, 0);
    chk("s1_cvg_sticky", {31'd0, cvg}, 1);

    // 2: three iterated loads, flag seen at the fourth check (S+19)
    conv = 1'b0; start = 1'b1;
    tick(); start = 1'b0;                          // S+1
    chk("s2_cvg_cleared", {31'd0, cvg}, 0);
    chk("s2_en_init", {31'd0, en0}, 1);
    for (int k = 2; k <= 20; k++) begin
      conv = (k - 1 >= 17);
      tick();                                      // S+k
      chk($sformatf("s2_en_%0d", k), {31'd0, en0},
          ((k == 6) || (k == 11) || (k == 16)) ? 1 : 0);
      chk($sformatf("s2_en1_%0d", k), {31'd0, en1},
          ((k == 6) || (k == 11) || (k == 16)) ? 1 : 0);
      chk($sformatf("s2_sel_%0d", k), {30'd0, sel0}, (k >= 6) ? 1 : 0);
      chk($sformatf("s2_done_%0d", k), {31'd0, done}, (k == 20) ? 1 : 0);
      chk($sformatf("s2_busy_%0d", k), {31'd0, busy}, (k < 20) ? 1 : 0);
      chk($sformatf("s2_iter_%0d", k), {24'd0, iter},
          (k >= 16) ? 3 : (k >= 11) ? 2 : (k >= 6) ? 1 : 0);
    end
    chk("s2_cvg", {31'd0, cvg}, 1);
    chk("s2_tmo", {31'd0, tmo}, 0);
    chk("s2_sel1_hold", {30'd0, sel1}, 1);
    conv = 1'b0;

    // 3: timeout on the MAX_ITER=4 instance
    start2 = 1'b1;
    tick(); start2 = 1'b0;                         // S+1
    chk("s3_en_init", {31'd0, en0_b}, 1);
    chk("s3_sel_init", {30'd0, sel0_b}, 0);
    loads = 0;
    for (int k = 2; k <= 26; k++) begin
      tick();
      if (en0_b) loads++;
      chk($sformatf("s3_en_%0d", k), {31'd0, en0_b},
          ((k == 6) || (k == 11) || (k == 16) || (k == 21)) ? 1 : 0);
      chk($sformatf("s3_done_%0d", k), {31'd0, done_b}, (k == 25) ? 1 : 0);
    end
    chk("s3_loads", loads, 4);
    chk("s3_iter", {24'd0, iter_b}, 4);
    chk("s3_tmo", {31'd0, tmo_b}, 1);
    chk("s3_cvg", {31'd0, cvg_b}, 0);
    chk("s3_busy", {31'd0, busy_b}, 0);
    chk("s3_sel1", {30'd0, sel1_b}, 1);
    chk("s3_en1", {31'd0, en1_b}, 0);
    chk("s3_other_idle", {31'd0, busy}, 0);

    // 4: start while busy ignored, abort at S+8
    start = 1'b1;
    tick(); start = 1'b0;                          // S+1
    chk("s4_sel_reinit", {30'd0, sel0}, 0);
    for (int k = 2; k <= 9; k++) begin
      start = ((k - 1) == 2) || ((k - 1) == 7);
      abort = ((k - 1) == 8);
      tick();                                      // S+k
      chk($sformatf("s4_en_%0d", k), {31'd0, en0}, (k == 6) ? 1 : 0);
      chk($sformatf("s4_busy_%0d", k), {31'd0, busy}, (k <= 8) ? 1 : 0);
      chk($sformatf("s4_done_%0d", k), {31'd0, done}, 0);
    end
    start = 1'b0; abort = 1'b0;
    chk("s4_iter_hold", {24'd0, iter}, 1);
    chk("s4_cvg", {31'd0, cvg}, 0);
    chk("s4_tmo", {31'd0, tmo}, 0);
    tick(); tick();
    chk("s4_idle_en", {31'd0, en0}, 0);
    chk("s4_idle_busy", {31'd0, busy}, 0);
    chk("s4_idle_done", {31'd0, done}, 0);

    // 5: rst while in WAIT_U (S+10, after first load), then a normal run
    start = 1'b1;
    tick(); start = 1'b0;                          // S+1
    for (int k = 2; k <= 10; k++) tick();          // S+10
    chk("s5_busy_pre", {31'd0, busy}, 1);
    chk("s5_iter_pre", {24'd0, iter}, 1);
    chk("s5_sel_pre", {30'd0, sel0}, 1);
    rst = 1'b1;
    tick();                                        // S+11: load suppressed
    rst = 1'b0;
    chk("s5_rst_en", {31'd0, en0}, 0);
    chk("s5_rst_sel", {30'd0, sel0}, 0);
    chk("s5_rst_busy", {31'd0, busy}, 0);
    chk("s5_rst_iter", {24'd0, iter}, 0);
    chk("s5_rst_done", {31'd0, done}, 0);
    conv = 1'b1; start = 1'b1;
    tick(); start = 1'b0;                          // S'+1
    chk("s5_run_en", {31'd0, en0}, 1);
    tick(); tick(); tick();                        // S'+4
    chk("s5_run_nodone", {31'd0, done}, 0);
    tick();                                        // S'+5
    chk("s5_run_done", {31'd0, done}, 1);
    chk("s5_run_cvg", {31'd0, cvg}, 1);
    tick();
    conv = 1'b0;

    // 6: start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    chk("s6_en", {31'd0, en0}, 0);
    chk("s6_busy", {31'd0, busy}, 0);
    chk("s6_cvg_kept", {31'd0, cvg}, 1);
    tick();
    chk("s6_busy_later", {31'd0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
